// File: rtl/seg7_scan4_pkg.sv
// seg7_scan4_pkg: segment patterns, digit count and scan state type shared by the display scanner.
package seg7_scan4_pkg;
    localparam int N_DIGITS = 4;
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;
    typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
endpackage

// File: rtl/seg7_scan4_bcd_to_seg7.sv
// bcd_to_seg7: active-high BCD to {g,f,e,d,c,b,a} decoder; nibbles A-F show a dash.
module bcd_to_seg7 import seg7_scan4_pkg::*; (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg7_scan4.sv
// seg7_scan4: 4-digit multiplexed 7-segment scanner with blank interval, frame capture,
// leading-zero blanking, per-digit enables and registered, polarity-selectable pins.
module seg7_scan4 import seg7_scan4_pkg::*; #(
    parameter int SCAN_DIV   = 16,
    parameter int BLANK_CYC  = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic                  lz_blank,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out
);
    localparam int SW = $clog2(SCAN_DIV);

    logic [SW-1:0]           slot_q, slot_d;
    logic [1:0]              idx_q, idx_d;
    state_e                  state_q, state_d;
    logic [4*N_DIGITS-1:0]   fbcd_q;
    logic [N_DIGITS-1:0]     fdp_q, fen_q;
    logic                    flz_q;
    logic [6:0]              seg_q, seg_d, seg_dec;
    logic                    dpo_q, dpo_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    wrap, capture, lit, lz_hit;
    logic [3:0]              nib;

    always_comb begin
        wrap    = slot_q == SW'(SCAN_DIV - 1);
        capture = slot_q == '0 && idx_q == '0;
        slot_d  = wrap ? '0 : slot_q + 1'b1;
        idx_d   = wrap ? idx_q + 1'b1 : idx_q;
        state_d = slot_d < SW'(BLANK_CYC) ? ST_BLANK : ST_DRIVE;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            slot_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_BLANK;
            fbcd_q  <= '0;
            fdp_q   <= '0;
            fen_q   <= '0;
            flz_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            if (capture) begin
                fbcd_q <= bcd_in;
                fdp_q  <= dp_in;
                fen_q  <= digit_en;
                flz_q  <= lz_blank;
            end
        end
    end

    assign nib = fbcd_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd_i (nib),
        .seg_o (seg_dec)
    );

    // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
    always_comb begin
        lz_hit = flz_q && idx_q != 2'd0 && (fbcd_q >> {idx_q, 2'b00}) == '0;
        lit    = state_q == ST_DRIVE && fen_q[idx_q];
        seg_d  = lit && !lz_hit ? seg_dec : SEG_OFF;
        dpo_d  = lit && fdp_q[idx_q];
        an_d   = lit ? 4'b0001 << idx_q : 4'b0000;
    end

    // Polarity is applied only here so the internal logic stays active-high.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            seg_q <= {7{ACTIVE_LOW}};
            dpo_q <= ACTIVE_LOW;
            an_q  <= {N_DIGITS{ACTIVE_LOW}};
        end else begin
            seg_q <= seg_d ^ {7{ACTIVE_LOW}};
            dpo_q <= dpo_d ^ ACTIVE_LOW;
            an_q  <= an_d ^ {N_DIGITS{ACTIVE_LOW}};
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dpo_q;
    assign an_out  = an_q;
endmodule
